// File: rtl/multiplier_unit.sv
// Fixed-point integer multiplier with trigger/ready/done handshake.
// MUL_TYPE picks single-cycle, two-stage split, radix-4 shift-add or radix-4 Booth.
module multiplier_unit #(
    parameter int unsigned C_WIDTH     = 32,
    parameter int unsigned FIXED_POINT = 0,
    parameter int unsigned MUL_TYPE    = 0
) (
    input  logic               ctl_clk,
    input  logic               reset,
    input  logic [C_WIDTH-1:0] a,
    input  logic [C_WIDTH-1:0] b,
    input  logic               signed_cal,
    input  logic               trigger,
    output logic               ready,
    output logic               done,
    output logic [C_WIDTH-1:0] y
);

    localparam int unsigned W     = C_WIDTH;
    localparam int unsigned PW    = 2 * W;
    localparam int unsigned H     = W / 2;
    localparam int unsigned BW    = W + 2;
    localparam int unsigned CW    = $clog2(H + 2);
    localparam int unsigned LBASE = (MUL_TYPE == 0) ? 0 : (MUL_TYPE == 1) ? 1 : H - 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nxt;
    logic            ready_nxt, done_nxt;
    logic            accept_c, final_c;
    logic [CW-1:0]   cnt, last;
    logic [PW-1:0]   acc, mcand;
    logic [BW-1:0]   breg;
    logic            prev;
    logic [PW-1:0]   bx, bhi, add_c, acc_nxt, mcand_nxt, prod_c;
    logic [BW-1:0]   breg_nxt;
    logic            neg_c;

    assign accept_c = (state != BUSY) && trigger;
    assign final_c  = (state == BUSY) && (cnt == last);

    // State register
    always_ff @(posedge ctl_clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trigger) state_nxt = BUSY;
            BUSY:    if (final_c) state_nxt = DONE;
            DONE:    state_nxt = trigger ? BUSY : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode, registered below so ready/done align with the state
    always_comb begin
        ready_nxt = 1'b1;
        done_nxt  = 1'b0;
        if (state_nxt == BUSY) ready_nxt = 1'b0;
        if (state_nxt == DONE) done_nxt  = 1'b1;
    end

    // One compute step of the selected architecture; prod_c is valid on the final step
    always_comb begin
        bx        = {{(PW-BW){breg[BW-1]}}, breg};
        bhi       = PW'($signed(bx) >>> H);
        add_c     = '0;
        neg_c     = 1'b0;
        acc_nxt   = acc;
        mcand_nxt = mcand << 2;
        breg_nxt  = {breg[BW-1], breg[BW-1], breg[BW-1:2]};
        prod_c    = acc;
        case (MUL_TYPE)
            1: begin
                mcand_nxt = mcand;
                if (cnt == '0) begin
                    acc_nxt   = mcand * PW'(breg[H-1:0]);
                    mcand_nxt = (mcand * bhi) << H;
                end
                prod_c = acc + mcand;
            end
            2: begin
                case (breg[1:0])
                    2'd1:    add_c = mcand;
                    2'd2:    add_c = mcand << 1;
                    2'd3:    add_c = mcand + (mcand << 1);
                    default: add_c = '0;
                endcase
                acc_nxt = acc + add_c;
                // Negative multiplier MSB carries weight -2^W; remove the 2^W*a it added
                prod_c  = breg[BW-1] ? (acc_nxt - (mcand << 2)) : acc_nxt;
            end
            3: begin
                case ({breg[1:0], prev})
                    3'b001, 3'b010: add_c = mcand;
                    3'b011:         add_c = mcand << 1;
                    3'b100: begin add_c = mcand << 1; neg_c = 1'b1; end
                    3'b101, 3'b110: begin add_c = mcand; neg_c = 1'b1; end
                    default:        add_c = '0;
                endcase
                acc_nxt = neg_c ? (acc - add_c) : (acc + add_c);
                prod_c  = acc_nxt;
            end
            default: begin
                prod_c = mcand * bx;
            end
        endcase
    end

    // Operand latch, iteration registers and result
    always_ff @(posedge ctl_clk) begin
        if (reset) begin
            ready <= 1'b1;
            done  <= 1'b0;
            y     <= '0;
            acc   <= '0;
            mcand <= '0;
            breg  <= '0;
            prev  <= 1'b0;
            cnt   <= '0;
            last  <= '0;
        end else begin
            ready <= ready_nxt;
            done  <= done_nxt;
            if (accept_c) begin
                mcand <= signed_cal ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
                breg  <= signed_cal ? {b[W-1], b[W-1], b} : {2'b00, b};
                acc   <= '0;
                prev  <= 1'b0;
                cnt   <= '0;
                // Unsigned Booth needs one extra zero guard digit
                last  <= (MUL_TYPE == 3 && !signed_cal) ? CW'(LBASE + 1) : CW'(LBASE);
            end else if (state == BUSY) begin
                acc   <= acc_nxt;
                mcand <= mcand_nxt;
                breg  <= breg_nxt;
                prev  <= breg[1];
                cnt   <= cnt + CW'(1);
                if (final_c) y <= W'(prod_c >> FIXED_POINT);
            end
        end
    end

endmodule

// File: tb/tb_multiplier_unit.sv
// Directed bench: eight 8-bit instances (types 0..3 at FIXED_POINT 0 and 4) checked
// against hand-computed vectors, plus busy-trigger, back-to-back and reset sequences.
module tb_multiplier_unit;

    logic            clk = 1'b0;
    logic            reset;
    logic [7:0]      a, b;
    logic            sgn;
    logic [7:0]      trig;
    logic [7:0]      ready_v, done_v;
    logic [7:0][7:0] y_v;
    logic [7:0]      prev_y [8];
    int              checks = 0;
    int              failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 8; g++) begin : g_dut
        multiplier_unit #(
            .C_WIDTH    (8),
            .FIXED_POINT((g < 4) ? 0 : 4),
            .MUL_TYPE   (g % 4)
        ) u_dut (
            .ctl_clk   (clk),
            .reset     (reset),
            .a         (a),
            .b         (b),
            .signed_cal(sgn),
            .trigger   (trig[g]),
            .ready     (ready_v[g]),
            .done      (done_v[g]),
            .y         (y_v[g])
        );
    end

    typedef struct {
        logic       s;
        logic [7:0] av;
        logic [7:0] bv;
        logic [7:0] y0;
        logic [7:0] y4;
        bit         disturb;
    } vec_t;

    task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d got=%h expected=%h", name, idx, act, exp);
        end
    endtask

    function automatic int lat(input int i, input logic s);
        case (i % 4)
            0:       return 1;
            1:       return 2;
            2:       return 4;
            default: return s ? 4 : 5;
        endcase
    endfunction

    // One triggered operation on all instances, cycle-by-cycle handshake and result checks
    task automatic run_op(input vec_t v);
        @(negedge clk);
        a = v.av; b = v.bv; sgn = v.s; trig = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        trig = 8'h00;
        for (int i = 0; i < 8; i++) begin
            check("busy_ready", i, 8'(ready_v[i]), 8'd0);
            check("busy_done", i, 8'(done_v[i]), 8'd0);
        end
        if (v.disturb) begin
            a = ~v.av; b = v.bv ^ 8'h5A; sgn = ~v.s; trig = 8'hFF;
        end
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            @(negedge clk);
            trig = 8'h00;
            for (int i = 0; i < 8; i++) begin
                int         l;
                logic [7:0] ey;
                l  = lat(i, v.s);
                ey = (i < 4) ? v.y0 : v.y4;
                check("done", i, 8'(done_v[i]), 8'(c == l));
                check("ready", i, 8'(ready_v[i]), 8'(c >= l));
                check((c < l) ? "y_hold" : "y", i, y_v[i], (c < l) ? prev_y[i] : ey);
            end
        end
        for (int i = 0; i < 8; i++) prev_y[i] = (i < 4) ? v.y0 : v.y4;
        a = v.av; b = v.bv; sgn = v.s;
    endtask

    // Trigger held high on one instance: three results at period L+1
    task automatic b2b(input int idx, input logic s, input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] ey);
        int l;
        int nd;
        int edge_at [3];
        l  = lat(idx, s);
        nd = 0;
        @(negedge clk);
        a = av; b = bv; sgn = s; trig = 8'h00; trig[idx] = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (done_v[idx] && nd < 3) begin
                edge_at[nd] = e;
                check("b2b_y", idx, y_v[idx], ey);
                nd++;
                if (nd == 3) trig = 8'h00;
            end
        end
        trig = 8'h00;
        check("b2b_count", idx, 8'(nd), 8'd3);
        for (int k = 0; k < nd; k++)
            check("b2b_edge", idx, 8'(edge_at[k]), 8'((k + 1) * (l + 1)));
        check("b2b_idle_ready", idx, 8'(ready_v[idx]), 8'd1);
        prev_y[idx] = ey;
    endtask

    vec_t vecs [10];

    initial begin
        vecs[0] = '{1'b0, 8'h75, 8'h13, 8'hAF, 8'h8A, 1'b0};
        vecs[1] = '{1'b1, 8'h05, 8'hFD, 8'hF1, 8'hFF, 1'b0};
        vecs[2] = '{1'b0, 8'h05, 8'hFD, 8'hF1, 8'h4F, 1'b0};
        vecs[3] = '{1'b1, 8'h80, 8'h80, 8'h00, 8'h00, 1'b0};
        vecs[4] = '{1'b1, 8'h80, 8'h7F, 8'h80, 8'h08, 1'b0};
        vecs[5] = '{1'b0, 8'hFF, 8'hFF, 8'h01, 8'hE0, 1'b0};
        vecs[6] = '{1'b1, 8'hFF, 8'hFF, 8'h01, 8'h00, 1'b0};
        vecs[7] = '{1'b1, 8'h7F, 8'h7F, 8'h01, 8'hF0, 1'b0};
        vecs[8] = '{1'b0, 8'h00, 8'hAB, 8'h00, 8'h00, 1'b0};
        vecs[9] = '{1'b1, 8'h05, 8'hFD, 8'hF1, 8'hFF, 1'b1};

        // Reset held with trigger asserted: reset must win
        reset = 1'b1; a = 8'h33; b = 8'h44; sgn = 1'b0; trig = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; trig = 8'h00;
        for (int i = 0; i < 8; i++) begin
            check("rst_ready", i, 8'(ready_v[i]), 8'd1);
            check("rst_done", i, 8'(done_v[i]), 8'd0);
            check("rst_y", i, y_v[i], 8'h00);
            prev_y[i] = 8'h00;
        end
        @(negedge clk);
        for (int i = 0; i < 8; i++) check("post_rst_ready", i, 8'(ready_v[i]), 8'd1);

        for (int n = 0; n < 10; n++) run_op(vecs[n]);

        b2b(1, 1'b1, 8'h05, 8'hFD, 8'hF1);
        b2b(3, 1'b0, 8'h75, 8'h13, 8'hAF);
        b2b(3, 1'b1, 8'h80, 8'h7F, 8'h80);

        // Reset mid-operation aborts every instance
        @(negedge clk);
        a = 8'h75; b = 8'h13; sgn = 1'b0; trig = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        trig = 8'h00;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("abort_ready", i, 8'(ready_v[i]), 8'd1);
            check("abort_done", i, 8'(done_v[i]), 8'd0);
            check("abort_y", i, y_v[i], 8'h00);
            prev_y[i] = 8'h00;
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("abort_no_done", 2, 8'(done_v[2]), 8'd0);
        end
        run_op(vecs[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multiplier_unit.md
# multiplier_unit

Parameterised fixed-point integer multiplier with a trigger/ready/done handshake, used by the synthesizer datapath for gain, envelope and mixing products. One RTL block offers four selectable architectures that trade latency for area. All architectures produce bit-identical results for identical inputs. Signed (two's complement) or unsigned operation is selected per operation.

## Interface
- C_WIDTH, default 32: operand and result width in bits, ≥ 4, even.
- FIXED_POINT, default 0: number of fractional bits. The result is the full product shifted right by this amount. Range 0..C_WIDTH.
- MUL_TYPE, default 0: architecture selector.
  - 0: single-cycle.
  - 1: two-stage split.
  - 2: radix-4 shift-add.
  - 3: radix-4 Booth.
- ctl_clk, input, 1: sole clock. All logic updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- a, input, C_WIDTH: multiplicand.
- b, input, C_WIDTH: multiplier.
- signed_cal, input, 1: 1 = treat a and b as two's complement; 0 = unsigned.
- trigger, input, 1: start request. Level-sensitive and sampled only while ready = 1.
- ready, output, 1: idle, can accept trigger.
- done, output, 1: one-cycle pulse, y updated this cycle.
- y, output, C_WIDTH: result register.

## Operation
- FSM states: IDLE, BUSY, DONE.
  - IDLE → BUSY: trigger = 1 on a rising edge with ready = 1.
  - BUSY → DONE: after L compute cycles.
  - DONE → IDLE: unconditionally after one cycle. If trigger = 1 during DONE, DONE → BUSY instead, which gives back-to-back operation.
- On acceptance, latch a, b and signed_cal. Later input changes do not affect the running operation.
- Product P is 2·C_WIDTH bits wide.
  - signed_cal = 1: P = sext(a)·sext(b).
  - signed_cal = 0: P = zext(a)·zext(b).
- Output is y = P[FIXED_POINT +: C_WIDTH], i.e. arithmetic right shift by FIXED_POINT, truncating toward −∞.
- Overflow of the upper bits is discarded with no saturation.
- Architecture behaviour:
  - Type 0: behavioural full product in one cycle.
  - Type 1: two half-width partial-product groups, summed in the second cycle.
  - Type 2: consumes 2 multiplier bits per cycle, adding 0/1/2/3 × multiplicand. For signed operation, sign-extend the operands to an even width and apply a final correction for the negative multiplier MSB.
  - Type 3: radix-4 Booth recoding (digits −2..+2). For unsigned operation, extend the multiplier with one zero guard digit.
- y holds its value between done pulses.
- Trigger while ready = 0 is ignored; no queuing.

## Timing
- Reset values: y = 0, done = 0, ready = 1, FSM = IDLE. Internal operand and accumulator registers are cleared.
- Reset mid-operation aborts the operation. y keeps its reset value and done is not produced.
- Trigger accepted at edge k:
  - ready = 0 from edge k onward.
  - done = 1 and new y from edge k + L, for exactly one cycle.
  - ready returns to 1 at edge k + L, coincident with done.
- Latency L:
  - Type 0: 1.
  - Type 1: 2.
  - Type 2: C_WIDTH/2.
  - Type 3: C_WIDTH/2, plus 1 when signed_cal = 0.
- Trigger held high continuously restarts on every done cycle, giving a throughput of one result per L+1 cycles.
- Reset and trigger asserted together: reset wins.

## Test plan
- C_WIDTH = 8, FIXED_POINT = 0, all four types, unsigned, a = 0x75, b = 0x13, 1-cycle trigger → y = 0xAF on done. Done is a single pulse at the latency stated for the type, and ready is low in between.
- Same instances, signed_cal = 1, a = 0x05, b = 0xFD (−3) → y = 0xF1 for every type.
- FIXED_POINT = 4, C_WIDTH = 8, a = 0x05, b = 0xFD:
  - signed → y = 0xFF (P = 0xFFF1).
  - unsigned → y = 0x4F (P = 0x04F1).
- Corner operands, C_WIDTH = 8, signed: 0x80 × 0x80 → P = 0x4000, y = 0x00; 0x80 × 0x7F → y = 0x80. Unsigned: 0xFF × 0xFF → y = 0x01.
- Apply trigger while busy and change a/b mid-operation → the extra trigger is ignored and the result reflects the latched operands. Trigger held high → back-to-back results every L+1 cycles.
- Assert reset mid-operation of a type 2 instance → next edge gives ready = 1, done = 0, y = 0. A new trigger afterwards computes correctly.
